// File: rtl/fp32_pkg.sv
// ============================================================================
// Module   : fp32_pkg
// Purpose  : Shared binary32 field widths, saturation constants, the unpacked
//            operand record and the alignment-shift saturation helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp32_pkg;

  // Field geometry of an IEEE-754 binary32 word
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int MANT_W  = MAN_W + 1;   // fraction plus hidden bit
  localparam int SHIFT_W = 5;
  localparam int FP_W    = 1 + EXP_W + MAN_W;

  // All-ones exponent marks NaN/Inf
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Shifting a 24-bit mantissa by 24 or more clears it, so 24 is enough
  localparam int SHIFT_SAT = 24;

  // Operand after unpacking: sign, effective exponent, mantissa with hidden bit
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  effexp;
    logic [MANT_W-1:0] mant;
  } fp32_unpacked_t;

  // Exponent difference clamped to the largest useful barrel-shifter amount
  function automatic logic [SHIFT_W-1:0] sat_shift(input logic [EXP_W-1:0] diff);
    if (diff > EXP_W'(SHIFT_SAT)) begin
      return SHIFT_W'(SHIFT_SAT);
    end
    return diff[SHIFT_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_align_prep_if.sv
// ============================================================================
// Module   : fp_align_prep_if
// Purpose  : Operand-in / aligned-pair-out handshake bundle for the adder
//            alignment front end. The slave side is the alignment block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_align_prep_if;
  import fp32_pkg::*;

  // Upstream operand channel
  logic                in_valid;
  logic                in_ready;
  logic [FP_W-1:0]     a;
  logic [FP_W-1:0]     b;
  logic                sub;

  // Downstream aligned-pair channel
  logic                out_valid;
  logic                out_ready;
  logic [MANT_W-1:0]   big_mant;
  logic [MANT_W-1:0]   small_mant;
  logic [SHIFT_W-1:0]  shift;
  logic [EXP_W-1:0]    exp_big;
  logic                sign_big;
  logic                eff_sub;
  logic                special;

  // Producer of operands and consumer of aligned pairs
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, big_mant, small_mant, shift,
    input  exp_big, sign_big, eff_sub, special
  );

  // The alignment block itself
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, big_mant, small_mant, shift,
    output exp_big, sign_big, eff_sub, special
  );

endinterface

`default_nettype wire

// File: rtl/fp_unpack.sv
// ============================================================================
// Module   : fp_unpack
// Purpose  : Combinational binary32 unpacker. Restores the hidden bit, maps
//            denormals to effective exponent 1, optionally inverts the sign
//            and flags an all-ones exponent (NaN/Inf).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_unpack
  import fp32_pkg::*;
(
  input  logic [FP_W-1:0] i_op,
  input  logic            i_flip_sign,
  output fp32_unpacked_t  o_unp,
  output logic            o_special
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_frac;

  assign w_exp  = i_op[FP_W-2 -: EXP_W];
  assign w_frac = i_op[MAN_W-1:0];

  // Denormals (and zero) carry no hidden bit and behave as exponent 1
  always_comb begin
    o_unp.sign   = i_op[FP_W-1] ^ i_flip_sign;
    o_unp.effexp = w_exp;
    o_unp.mant   = {1'b1, w_frac};
    if (w_exp == '0) begin
      o_unp.effexp = EXP_W'(1);
      o_unp.mant   = {1'b0, w_frac};
    end
  end

  // NaN/Inf are only flagged here; resolution happens further down the adder
  assign o_special = (w_exp == EXP_MAX);

endmodule

`default_nettype wire

// File: rtl/fp_align_prep.sv
// ============================================================================
// Module   : fp_align_prep
// Purpose  : Two-stage front end of the binary32 adder. Stage 1 unpacks both
//            operands, stage 2 orders them by magnitude and produces the
//            saturated right-shift amount for the smaller mantissa.
//            Both stages use a bubble-free valid/ready pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_align_prep
  import fp32_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  fp_align_prep_if.slave      bus
);

  // Pipeline control
  logic r_v1;
  logic r_v2;
  logic w_adv1;
  logic w_adv2;

  // Stage-1 results
  fp32_unpacked_t w_ua;
  fp32_unpacked_t w_ub;
  logic           w_spec_a;
  logic           w_spec_b;
  fp32_unpacked_t r_ua;
  fp32_unpacked_t r_ub;
  logic           r_special1;

  // Stage-2 combinational ordering
  logic               w_a_big;
  fp32_unpacked_t     w_big;
  fp32_unpacked_t     w_small;
  logic [EXP_W-1:0]   w_diff;
  logic [SHIFT_W-1:0] w_shift;
  logic               w_eff_sub;

  // Stage-2 output registers
  logic [MANT_W-1:0]  r_big_mant;
  logic [MANT_W-1:0]  r_small_mant;
  logic [SHIFT_W-1:0] r_shift;
  logic [EXP_W-1:0]   r_exp_big;
  logic               r_sign_big;
  logic               r_eff_sub;
  logic               r_special2;

  // A stage may load when it is empty or its content moves on this edge
  assign w_adv2 = !r_v2 || bus.out_ready;
  assign w_adv1 = !r_v1 || w_adv2;

  assign bus.in_ready = w_adv1;

  // ---------------------------------------------------------------- stage 1
  fp_unpack u_unpack_a (
    .i_op        (bus.a),
    .i_flip_sign (1'b0),
    .o_unp       (w_ua),
    .o_special   (w_spec_a)
  );

  fp_unpack u_unpack_b (
    .i_op        (bus.b),
    .i_flip_sign (bus.sub),
    .o_unp       (w_ub),
    .o_special   (w_spec_b)
  );

  // Capture the unpacked pair whenever stage 1 can advance and data is offered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1       <= 1'b0;
      r_ua       <= '0;
      r_ub       <= '0;
      r_special1 <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_ua       <= w_ua;
        r_ub       <= w_ub;
        r_special1 <= w_spec_a | w_spec_b;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  // Order by {effexp, mant}; ties favour A so equal magnitudes keep Big=A
  always_comb begin
    w_a_big   = ({r_ua.effexp, r_ua.mant} >= {r_ub.effexp, r_ub.mant});
    w_big     = r_ub;
    w_small   = r_ua;
    if (w_a_big) begin
      w_big   = r_ua;
      w_small = r_ub;
    end
    w_diff    = w_big.effexp - w_small.effexp;
    w_shift   = sat_shift(w_diff);
    w_eff_sub = r_ua.sign ^ r_ub.sign;
  end

  // Output registers hold steady until the downstream consumer takes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2         <= 1'b0;
      r_big_mant   <= '0;
      r_small_mant <= '0;
      r_shift      <= '0;
      r_exp_big    <= '0;
      r_sign_big   <= 1'b0;
      r_eff_sub    <= 1'b0;
      r_special2   <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_big_mant   <= w_big.mant;
        r_small_mant <= w_small.mant;
        r_shift      <= w_shift;
        r_exp_big    <= w_big.effexp;
        r_sign_big   <= w_big.sign;
        r_eff_sub    <= w_eff_sub;
        r_special2   <= r_special1;
      end
    end
  end

  assign bus.out_valid  = r_v2;
  assign bus.big_mant   = r_big_mant;
  assign bus.small_mant = r_small_mant;
  assign bus.shift      = r_shift;
  assign bus.exp_big    = r_exp_big;
  assign bus.sign_big   = r_sign_big;
  assign bus.eff_sub    = r_eff_sub;
  assign bus.special    = r_special2;

endmodule

`default_nettype wire

// File: tb/tb_fp_align_prep.sv
// ============================================================================
// Module   : tb_fp_align_prep
// Purpose  : Directed self-checking bench for the adder alignment front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_align_prep;
  import fp32_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  fp_align_prep_if ifc();

  fp_align_prep dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // All data outputs packed: big(24) small(24) shift(5) exp(8) sign eff special
  logic [63:0] obs;
  assign obs = {ifc.big_mant, ifc.small_mant, ifc.shift, ifc.exp_big,
                ifc.sign_big, ifc.eff_sub, ifc.special};

  function automatic logic [63:0] mk(input logic [23:0] bm, input logic [23:0] sm,
                                     input logic [4:0] sh, input logic [7:0] eb,
                                     input logic sg, input logic es, input logic sp);
    return {bm, sm, sh, eb, sg, es, sp};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // One isolated pair: accept, confirm nothing after one cycle, check after two
  task automatic apply(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, input logic [63:0] want);
    @(negedge clk);
    ifc.a        = av;
    ifc.b        = bv;
    ifc.sub      = sv;
    ifc.in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(ifc.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(ifc.out_valid), 64'd1);
    chk({tag, "_data"}, obs, want);
  endtask

  logic [31:0] sa [5];
  logic [31:0] sb [5];
  logic        ss [5];
  logic [63:0] se [5];
  logic [63:0] snap;
  logic        held;
  int          idx;
  int          sent;

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.sub       = 1'b0;
    ifc.out_ready = 1'b1;
    held = 1'b0;
    snap = '0;
    idx  = 0;
    sent = 0;

    // Reset state
    #1;
    chk("reset_valid", 64'(ifc.out_valid), 64'd0);
    chk("reset_data", obs, 64'd0);
    #11 rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(ifc.in_ready), 64'd1);

    // Timing and basic ordering: 1.0 + 2.0
    apply("t1_1p0_2p0", 32'h3F800000, 32'h40000000, 1'b0,
          mk(24'h800000, 24'h800000, 5'd1, 8'h80, 1'b0, 1'b0, 1'b0));
    // Larger operand negative: 1.0 + (-2.0)
    apply("t1_neg_big", 32'h3F800000, 32'hC0000000, 1'b0,
          mk(24'h800000, 24'h800000, 5'd1, 8'h80, 1'b1, 1'b1, 1'b0));

    // Shift saturation
    apply("t2_diff24", 32'h4B800000, 32'h3F800000, 1'b0,
          mk(24'h800000, 24'h800000, 5'd24, 8'h97, 1'b0, 1'b0, 1'b0));
    apply("t2_diff25", 32'h4C000000, 32'h3F800000, 1'b0,
          mk(24'h800000, 24'h800000, 5'd24, 8'h98, 1'b0, 1'b0, 1'b0));
    apply("t2_diff127", 32'h7F000000, 32'h3F800000, 1'b0,
          mk(24'h800000, 24'h800000, 5'd24, 8'hFE, 1'b0, 1'b0, 1'b0));

    // Ties with subtraction
    apply("t3_tie_sub", 32'h40400000, 32'h40400000, 1'b1,
          mk(24'hC00000, 24'hC00000, 5'd0, 8'h80, 1'b0, 1'b1, 1'b0));
    apply("t3_tie_neg", 32'hC0400000, 32'h40400000, 1'b1,
          mk(24'hC00000, 24'hC00000, 5'd0, 8'h80, 1'b1, 1'b0, 1'b0));

    // Denormals and zero
    apply("t4_denorm_zero", 32'h00000001, 32'h00000000, 1'b0,
          mk(24'h000001, 24'h000000, 5'd0, 8'h01, 1'b0, 1'b0, 1'b0));
    apply("t4_min_norm", 32'h00800000, 32'h00400000, 1'b0,
          mk(24'h800000, 24'h400000, 5'd0, 8'h01, 1'b0, 1'b0, 1'b0));

    // Backpressure: five back-to-back pairs, downstream stalled cycles 3..6
    sa[0] = 32'h3F800000; sb[0] = 32'h40000000; ss[0] = 1'b0;
    se[0] = mk(24'h800000, 24'h800000, 5'd1, 8'h80, 1'b0, 1'b0, 1'b0);
    sa[1] = 32'h4B800000; sb[1] = 32'h3F800000; ss[1] = 1'b0;
    se[1] = mk(24'h800000, 24'h800000, 5'd24, 8'h97, 1'b0, 1'b0, 1'b0);
    sa[2] = 32'h40400000; sb[2] = 32'h40400000; ss[2] = 1'b1;
    se[2] = mk(24'hC00000, 24'hC00000, 5'd0, 8'h80, 1'b0, 1'b1, 1'b0);
    sa[3] = 32'h00800000; sb[3] = 32'h00400000; ss[3] = 1'b0;
    se[3] = mk(24'h800000, 24'h400000, 5'd0, 8'h01, 1'b0, 1'b0, 1'b0);
    sa[4] = 32'hC0400000; sb[4] = 32'h40400000; ss[4] = 1'b1;
    se[4] = mk(24'hC00000, 24'hC00000, 5'd0, 8'h80, 1'b1, 1'b0, 1'b0);

    for (int c = 0; c < 40 && idx < 5; c++) begin
      @(negedge clk);
      ifc.out_ready = !(c >= 3 && c <= 6);
      ifc.in_valid  = (sent < 5);
      if (sent < 5) begin
        ifc.a   = sa[sent];
        ifc.b   = sb[sent];
        ifc.sub = ss[sent];
      end
      #1;
      if (held) chk($sformatf("t5_hold_c%0d", c), obs, snap);
      if (c == 3 || c == 6) chk($sformatf("t5_stall_ready_c%0d", c), 64'(ifc.in_ready), 64'd0);
      if (c == 7) chk("t5_resume_ready", 64'(ifc.in_ready), 64'd1);
      if (ifc.out_valid && ifc.out_ready) begin
        chk($sformatf("t5_pair%0d", idx), obs, se[idx]);
        idx++;
      end
      held = ifc.out_valid && !ifc.out_ready;
      snap = obs;
      if (ifc.in_valid && ifc.in_ready) sent++;
    end
    @(negedge clk);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    chk("t5_count", 64'(idx), 64'd5);
    chk("t5_drain", 64'(ifc.out_valid), 64'd0);

    // Asynchronous reset with two pairs in flight
    @(negedge clk);
    ifc.a = sa[0]; ifc.b = sb[0]; ifc.sub = ss[0]; ifc.in_valid = 1'b1;
    @(negedge clk);
    ifc.a = sa[1]; ifc.b = sb[1]; ifc.sub = ss[1];
    @(negedge clk);
    ifc.in_valid = 1'b0;
    #2;
    chk("t6_pre_valid", 64'(ifc.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("t6_rst_data", obs, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("t6_rel_ready", 64'(ifc.in_ready), 64'd1);
    chk("t6_rel_valid", 64'(ifc.out_valid), 64'd0);
    apply("t6_special", 32'h7F800000, 32'h3F800000, 1'b0,
          mk(24'h800000, 24'h800000, 5'd24, 8'hFF, 1'b0, 1'b0, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
